// File: rtl/viterbi_pkg.sv
// Shared types and helpers for the 2-state rate-1/2 Viterbi decoder.
// The optional error counter is enabled by VITERBI_ERRCNT_EN (see viterbi_decoder).
package viterbi_pkg;

    localparam int METRIC_W_DEF = 3;

    typedef logic [METRIC_W_DEF-1:0] pm_t;

    localparam logic STATE0 = 1'b0;
    localparam logic STATE1 = 1'b1;

    function automatic logic [1:0] hamming2(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] x;
        x = a ^ b;
        return {1'b0, x[1]} + {1'b0, x[0]};
    endfunction

    function automatic logic [1:0] expected_sym(input logic s, input logic d);
        return {d ^ s, d};
    endfunction

endpackage

// File: rtl/viterbi_acs.sv
// Add-compare-select for one destination state d: picks the cheaper of the two predecessors.
// The returned metric is one bit wider than PM so the sum cannot wrap before normalisation.
module viterbi_acs
    import viterbi_pkg::*;
#(
    parameter int METRIC_W = 3
) (
    input  logic [METRIC_W-1:0] pm0,
    input  logic [METRIC_W-1:0] pm1,
    input  logic [1:0]          data_in,
    input  logic                d,
    output logic [METRIC_W:0]   pm_new,
    output logic                sel
);

    localparam int W = METRIC_W + 1;

    logic [METRIC_W:0] c0;
    logic [METRIC_W:0] c1;

    always_comb begin
        c0     = {1'b0, pm0} + W'(hamming2(data_in, expected_sym(STATE0, d)));
        c1     = {1'b0, pm1} + W'(hamming2(data_in, expected_sym(STATE1, d)));
        // a tie keeps predecessor state 0
        sel    = (c1 < c0);
        pm_new = sel ? c1 : c0;
    end

endmodule

// File: rtl/viterbi_decoder.sv
// Hard-decision Viterbi decoder, register-exchange survivors, fixed decision depth TB_DEPTH.
// Define VITERBI_ERRCNT_EN to add the err_count port (channel syndrome-error counter).
module viterbi_decoder
    import viterbi_pkg::*;
#(
    parameter int TB_DEPTH = 8,
    parameter int METRIC_W = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  data_in,
    input  logic        in_valid,
    output logic        data_out,
    output logic        out_valid
`ifdef VITERBI_ERRCNT_EN
    ,
    output logic [15:0] err_count
`endif
);

    localparam int FILL_W = $clog2(TB_DEPTH + 1);
    localparam logic [FILL_W-1:0]   FILL_MAX = FILL_W'(TB_DEPTH);
    localparam logic [FILL_W-1:0]   FILL_LAST = FILL_W'(TB_DEPTH - 1);
    localparam logic [METRIC_W-1:0] PM_MAX = '1;
    localparam logic [TB_DEPTH-1:0] ONE_LSB = TB_DEPTH'(1);

    logic [METRIC_W-1:0] pm0, pm1, pm0_n, pm1_n;
    logic [METRIC_W:0]   raw0, raw1, pm_min;
    logic                sel0, sel1, dec_bit;
    logic [TB_DEPTH-1:0] surv0, surv1, surv_s0, surv_s1, surv0_n, surv1_n;
    logic [FILL_W-1:0]   fill;

    function automatic logic [METRIC_W-1:0] sat(input logic [METRIC_W:0] v);
        return (v > {1'b0, PM_MAX}) ? PM_MAX : v[METRIC_W-1:0];
    endfunction

    viterbi_acs #(.METRIC_W(METRIC_W)) u_acs0 (
        .pm0(pm0), .pm1(pm1), .data_in(data_in), .d(STATE0), .pm_new(raw0), .sel(sel0)
    );

    viterbi_acs #(.METRIC_W(METRIC_W)) u_acs1 (
        .pm0(pm0), .pm1(pm1), .data_in(data_in), .d(STATE1), .pm_new(raw1), .sel(sel1)
    );

    always_comb begin
        pm_min  = (raw1 < raw0) ? raw1 : raw0;
        pm0_n   = sat(raw0 - pm_min);
        pm1_n   = sat(raw1 - pm_min);
        surv_s0 = sel0 ? surv1 : surv0;
        surv_s1 = sel1 ? surv1 : surv0;
        surv0_n = surv_s0 << 1;
        surv1_n = (surv_s1 << 1) | ONE_LSB;
        // best state is the lower metric, tie to state 0
        dec_bit = (raw1 < raw0) ? surv1_n[TB_DEPTH-1] : surv0_n[TB_DEPTH-1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pm0       <= '0;
            pm1       <= PM_MAX;
            surv0     <= '0;
            surv1     <= '0;
            fill      <= '0;
            data_out  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (in_valid) begin
                pm0       <= pm0_n;
                pm1       <= pm1_n;
                surv0     <= surv0_n;
                surv1     <= surv1_n;
                data_out  <= dec_bit;
                out_valid <= (fill >= FILL_LAST);
                if (fill != FILL_MAX) fill <= fill + 1'b1;
            end
        end
    end

`ifdef VITERBI_ERRCNT_EN
    logic prev_rx0;
    logic syndrome;

    assign syndrome = data_in[1] ^ data_in[0] ^ prev_rx0;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_rx0  <= 1'b0;
            err_count <= '0;
        end else if (in_valid) begin
            prev_rx0 <= data_in[0];
            if (syndrome && (err_count != 16'hFFFF)) err_count <= err_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_viterbi_decoder.sv
// Scoreboard bench for viterbi_decoder: an encoder model pushes each information bit,
// a monitor pops one per out_valid strobe; channel errors are injected sparsely.
module tb_viterbi_decoder;

    localparam int TB_DEPTH = 8;
    localparam int FILL = TB_DEPTH - 1;

    logic       clk;
    logic       reset;
    logic [1:0] data_in;
    logic       in_valid;
    logic       data_out;
    logic       out_valid;
`ifdef VITERBI_ERRCNT_EN
    logic [15:0] err_count;
`endif

    viterbi_decoder #(.TB_DEPTH(TB_DEPTH), .METRIC_W(3)) dut (
        .clk(clk),
        .reset(reset),
        .data_in(data_in),
        .in_valid(in_valid),
        .data_out(data_out),
        .out_valid(out_valid)
`ifdef VITERBI_ERRCNT_EN
        ,
        .err_count(err_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_tests = 0;
    int   n_fail = 0;
    logic exp_q[$];
    int   out_cnt = 0;
    int   seg_acc = 0;
    logic enc_s = 1'b0;
    logic prv_rx0 = 1'b0;
    int   err_m = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic monitor();
        logic acc;
        logic e;
        forever begin
            @(posedge clk);
            acc = in_valid && !reset;
            @(negedge clk);
            if (!acc) chk("no_strobe_without_symbol", int'(out_valid), 0);
            if (out_valid === 1'b1) begin
                out_cnt++;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL scoreboard_underflow: got out_valid=1 expected no output at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("data_out", int'(data_out), int'(e));
                end
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        idle(2);
        reset   = 1'b0;
        exp_q.delete();
        out_cnt = 0;
        seg_acc = 0;
        enc_s   = 1'b0;
        prv_rx0 = 1'b0;
        err_m   = 0;
        chk("reset_data_out", int'(data_out), 0);
        chk("reset_out_valid", int'(out_valid), 0);
`ifdef VITERBI_ERRCNT_EN
        chk("reset_err_count", int'(err_count), 0);
`endif
    endtask

    // encode one bit, optionally corrupt the symbol, present it for one accepted cycle
    task automatic send_bit(input logic b, input logic [1:0] flip, input int gap);
        logic [1:0] sym;
        sym = {b ^ enc_s, b} ^ flip;
        enc_s = b;
        exp_q.push_back(b);
        err_m += int'(sym[1] ^ sym[0] ^ prv_rx0);
        prv_rx0 = sym[0];
        seg_acc++;
        data_in  = sym;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        data_in  = 2'($urandom);
        idle(gap);
    endtask

    task automatic end_segment(input string name);
        idle(2);
        chk({name, "_out_count"}, out_cnt, (seg_acc > FILL) ? seg_acc - FILL : 0);
`ifdef VITERBI_ERRCNT_EN
        chk({name, "_err_count"}, int'(err_count), err_m);
`endif
    endtask

    logic clean_bits[12] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    initial begin
        logic [1:0] flip;
        int         pos;
        reset    = 1'b1;
        in_valid = 1'b0;
        data_in  = 2'b00;
        fork
            monitor();
        join_none

        do_reset();
        foreach (clean_bits[i]) send_bit(clean_bits[i], 2'b00, 0);
        end_segment("clean");

        do_reset();
        foreach (clean_bits[i]) send_bit(clean_bits[i], (i == 2) ? 2'b01 : 2'b00, 0);
        end_segment("one_error");

        do_reset();
        foreach (clean_bits[i]) send_bit(clean_bits[i], 2'b00, 1);
        end_segment("toggled_valid");

        do_reset();
        for (int i = 0; i < 5; i++) send_bit(clean_bits[i], 2'b00, 0);
        do_reset();
        foreach (clean_bits[i]) send_bit(clean_bits[i], 2'b00, 0);
        end_segment("reset_midstream");

        do_reset();
        for (int i = 0; i < 20; i++) send_bit(1'b0, 2'b00, 0);
        end_segment("all_zero");

        // one channel bit error per 12-symbol block, kept at least 4 symbols apart
        do_reset();
        for (int blk = 0; blk < 834; blk++) begin
            pos = $urandom_range(2, 9);
            for (int k = 0; k < 12; k++) begin
                flip = 2'b00;
                if (k == pos) flip = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01;
                send_bit(1'($urandom), flip, ($urandom_range(0, 3) == 0) ? 1 : 0);
            end
        end
        end_segment("random");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
